// File: rtl/apb_pkg.sv
// Shared APB types and constants for the APB master bridge and its bus interface.
package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    // Bridge transfer sequencing: SETUP and ACCESS are the two APB phases,
    // RESP holds the completed result until the requester takes it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mst_state_e;

endpackage

// File: rtl/apb_if.sv
// APB4 bus bundle with master, slave and monitor views, plus bus protocol checks.
interface apb_if
    import apb_pkg::*;
(
    input logic PCLK,
    input logic PRESETn
);

    logic  PSEL;
    logic  PENABLE;
    addr_t PADDR;
    logic  PWRITE;
    data_t PWDATA;
    strb_t PSTRB;
    logic  PREADY;
    data_t PRDATA;
    logic  PSLVERR;

    modport mst_mp (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slv_mp (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );

    modport monitor_mp (
        input PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input PREADY, PRDATA, PSLVERR
    );

    // PENABLE is only meaningful inside a selected transfer.
    property p_enable_needs_sel;
        @(posedge PCLK) disable iff (!PRESETn) PENABLE |-> PSEL;
    endproperty

    // A setup phase is always followed by an access phase with unchanged controls.
    property p_setup_to_access;
        @(posedge PCLK) disable iff (!PRESETn)
            (PSEL && !PENABLE) |=> (PSEL && PENABLE && $stable(PADDR) && $stable(PWRITE)
                                    && $stable(PWDATA) && $stable(PSTRB));
    endproperty

    // While the slave stalls, controls hold unless the master abandons the transfer.
    property p_wait_stable;
        @(posedge PCLK) disable iff (!PRESETn)
            (PSEL && PENABLE && !PREADY) |=> (!PSEL || ($stable(PADDR) && $stable(PWRITE)
                                               && $stable(PWDATA) && $stable(PSTRB)));
    endproperty

    a_enable_needs_sel: assert property (p_enable_needs_sel);
    a_setup_to_access:  assert property (p_setup_to_access);
    a_wait_stable:      assert property (p_wait_stable);

endinterface

// File: rtl/apb_mst_bridge.sv
// Single-outstanding APB4 master: valid/ready request in, APB transfer out,
// valid/ready response back, with a bounded wait for PREADY.
module apb_mst_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic  PCLK,
    input  logic  PRESETn,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_write,
    input  addr_t req_addr,
    input  data_t req_wdata,
    input  strb_t req_strb,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output data_t rsp_rdata,
    output logic  rsp_err,
    apb_if.mst_mp apb
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mst_state_e       state_reg, state_next;
    logic             psel_reg, psel_next;
    logic             penable_reg, penable_next;
    addr_t            paddr_reg, paddr_next;
    logic             pwrite_reg, pwrite_next;
    data_t            pwdata_reg, pwdata_next;
    strb_t            pstrb_reg, pstrb_next;
    logic             rsp_valid_reg, rsp_valid_next;
    data_t            rsp_rdata_reg, rsp_rdata_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept;
    logic             timeout_hit;

    // A new request can be taken when idle, or while the pending response is consumed.
    assign req_ready   = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LIMIT);

    // Next-state and next-output logic; every output is produced from a register.
    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        paddr_next     = paddr_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;
        pstrb_next     = pstrb_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        cnt_next       = cnt_reg;

        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
                cnt_next     = '0;
            end
            ACCESS: begin
                // PREADY takes priority over an expiring timeout in the same cycle.
                if (apb.PREADY) begin
                    state_next     = RESP;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite_reg ? '0 : apb.PRDATA;
                    rsp_err_next   = apb.PSLVERR;
                end else if (timeout_hit) begin
                    state_next     = RESP;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Acceptance loads the APB controls once; they then hold through ACCESS.
        // Reads leave PWDATA untouched and drive no strobes.
        if (accept) begin
            state_next   = SETUP;
            psel_next    = 1'b1;
            penable_next = 1'b0;
            paddr_next   = req_addr;
            pwrite_next  = req_write;
            pstrb_next   = req_write ? req_strb : '0;
            if (req_write) begin
                pwdata_next = req_wdata;
            end
        end
    end

    // State and output registers; reset drops any in-flight transfer immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            paddr_reg     <= '0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            paddr_reg     <= paddr_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
            pstrb_reg     <= pstrb_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign apb.PSEL    = psel_reg;
    assign apb.PENABLE = penable_reg;
    assign apb.PADDR   = paddr_reg;
    assign apb.PWRITE  = pwrite_reg;
    assign apb.PWDATA  = pwdata_reg;
    assign apb.PSTRB   = pstrb_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Directed and randomized checks of apb_mst_bridge against a memory-backed
// slave and a transaction-level reference model.
module tb_apb_mst_bridge;

    localparam int T = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 pclk = ~pclk;

    apb_if bus (.PCLK(pclk), .PRESETn(presetn));

    apb_mst_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .PCLK      (pclk),
        .PRESETn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_txn  = 0;

    // Slave configuration for the next transfer, and its own storage.
    int          cfg_wait;
    bit          cfg_err;
    int          wait_left;
    logic [31:0] slv_mem [8];

    // Reference model state and the expectations of the transfer in flight.
    logic [31:0] ref_mem [8];
    bit          exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: holds PREADY low cfg_wait access cycles, then completes from its memory.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        wait_left   = 0;
        for (int i = 0; i < 8; i++) slv_mem[i] = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (bus.PSEL && !bus.PENABLE) begin
                wait_left   = cfg_wait;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = $urandom;
            end else if (bus.PSEL && bus.PENABLE) begin
                if (wait_left > 0) begin
                    wait_left--;
                    bus.PREADY  = 1'b0;
                    bus.PSLVERR = 1'b0;
                    bus.PRDATA  = $urandom;
                end else begin
                    bus.PREADY  = 1'b1;
                    bus.PSLVERR = cfg_err;
                    bus.PRDATA  = slv_mem[bus.PADDR[4:2]];
                    if (bus.PWRITE && !cfg_err) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.PSTRB[b]) slv_mem[bus.PADDR[4:2]][8*b +: 8] = bus.PWDATA[8*b +: 8];
                    end
                end
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = $urandom;
            end
        end
    end

    // Presents a request and records what the transaction must produce.
    task automatic start_req(input bit w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s, input int waits, input bit err);
        bit tmo;
        tmo       = (waits > T);
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_strb  = s;
        req_valid = 1'b1;
        cfg_wait  = waits;
        cfg_err   = err;
        exp_write = w;
        exp_addr  = a;
        exp_wdata = wd;
        exp_pstrb = w ? s : 4'h0;
        exp_lat   = ((waits > T) ? T : waits) + 3;
        exp_err   = err || tmo;
        exp_rdata = (!w && !tmo) ? ref_mem[a[4:2]] : 32'h0;
        if (w && !err && !tmo) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[4:2]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // Called one cycle after the accepting edge; follows the transfer to its response.
    task automatic await_rsp(input string tag, output int lat);
        int k;
        bit strb_ok;
        req_valid = 1'b0;
        chk({tag, "_setup"}, {bus.PSEL, bus.PENABLE}, 2'b10);
        chk({tag, "_paddr"}, bus.PADDR, exp_addr);
        chk({tag, "_pwrite"}, bus.PWRITE, exp_write);
        chk({tag, "_pstrb"}, bus.PSTRB, exp_pstrb);
        if (exp_write) chk({tag, "_pwdata"}, bus.PWDATA, exp_wdata);
        @(negedge pclk);
        k = 2;
        chk({tag, "_access"}, {bus.PSEL, bus.PENABLE}, 2'b11);
        strb_ok = 1'b1;
        while (!rsp_valid && k < 40) begin
            if (bus.PSTRB !== exp_pstrb) strb_ok = 1'b0;
            @(negedge pclk);
            k++;
        end
        lat = k;
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_rsp_err"}, rsp_err, exp_err);
        chk({tag, "_bus_idle"}, {bus.PSEL, bus.PENABLE}, 2'b00);
        chk({tag, "_pstrb_held"}, strb_ok, 1'b1);
    endtask

    // Holds off the response for 'delay' cycles, then consumes it.
    task automatic consume(input string tag, input int delay);
        logic [31:0] hd;
        logic        he;
        hd        = rsp_rdata;
        he        = rsp_err;
        rsp_ready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge pclk);
            chk({tag, "_hold_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, he, hd});
            chk({tag, "_hold_req_ready"}, req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_release_req_ready"}, req_ready, 1'b1);
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
    endtask

    task automatic print_txn(input string tag, input int lat);
        n_txn++;
        $display("txn %0d %s %s addr=%h wdata=%h strb=%h waits=%0d slverr=%0d -> rdata=%h err=%0d lat=%0d",
                 n_txn, tag, exp_write ? "WR" : "RD", exp_addr, exp_wdata, exp_pstrb,
                 cfg_wait, cfg_err, rsp_rdata, rsp_err, lat);
    endtask

    task automatic run_txn(input string tag, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input int waits, input bit err, input int delay);
        int lat;
        start_req(w, a, wd, s, waits, err);
        #1;
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        @(negedge pclk);
        await_rsp(tag, lat);
        print_txn(tag, lat);
        consume(tag, delay);
    endtask

    initial begin
        int  lat;
        bit  quiet;
        bit  rw;
        logic [2:0]  ridx;
        logic [31:0] rdat;
        logic [3:0]  rstrb;
        int  rwait;
        bit  rerr;
        int  rdel;

        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b0;
        cfg_wait  = 0;
        cfg_err   = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        repeat (3) @(negedge pclk);
        chk("reset_apb_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}, 7'd0);
        chk("reset_paddr", bus.PADDR, 32'h0);
        chk("reset_pwdata", bus.PWDATA, 32'h0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("reset_req_ready", req_ready, 1'b1);

        // Directed scenarios, including the timeout boundary.
        run_txn("wr_zero_wait", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
        run_txn("rd_wait2",     1'b0, 32'h10, 32'h0,       4'hF, 2, 1'b0, 0);
        run_txn("slv_err",      1'b1, 32'h14, 32'h12345678, 4'hF, 0, 1'b1, 0);
        run_txn("rd_unwritten", 1'b0, 32'h14, 32'h0,       4'h0, 1, 1'b0, 0);
        run_txn("timeout",      1'b0, 32'h10, 32'h0,       4'h0, 7, 1'b0, 0);
        run_txn("ready_at_lim", 1'b0, 32'h10, 32'h0,       4'h0, 4, 1'b0, 0);
        run_txn("wr_partial",   1'b1, 32'h10, 32'hA5A5A5A5, 4'b0101, 1, 1'b0, 0);
        run_txn("rd_partial",   1'b0, 32'h10, 32'h0,       4'h0, 0, 1'b0, 1);

        // Response backpressure with a queued request, then back-to-back issue.
        start_req(1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 0, 1'b0);
        #1;
        chk("bp_req_ready", req_ready, 1'b1);
        @(negedge pclk);
        await_rsp("bp_wr", lat);
        print_txn("bp_wr", lat);
        start_req(1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0);
        consume("bp_wr", 3);
        await_rsp("b2b_rd", lat);
        print_txn("b2b_rd", lat);
        consume("b2b_rd", 0);

        // Reset in the middle of an ACCESS phase.
        start_req(1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0);
        #1;
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        chk("mid_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        presetn = 1'b0;
        #1;
        chk("mid_rst_apb_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}, 7'd0);
        chk("mid_rst_paddr", bus.PADDR, 32'h0);
        chk("mid_rst_pwdata", bus.PWDATA, 32'h0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge pclk);
            if (rsp_valid || bus.PSEL) quiet = 1'b0;
        end
        chk("mid_rst_no_rsp", quiet, 1'b1);
        run_txn("post_rst_rd", 1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, 1);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 30; i++) begin
            rw    = 1'($urandom_range(0, 1));
            ridx  = 3'($urandom_range(0, 7));
            rdat  = $urandom;
            rstrb = 4'($urandom_range(0, 15));
            rwait = $urandom_range(0, 6);
            rerr  = ($urandom_range(0, 7) == 0);
            rdel  = $urandom_range(0, 2);
            run_txn("rand", rw, {27'd0, ridx, 2'b00}, rdat, rstrb, rwait, rerr, rdel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_mst_bridge.md
# apb_mst_bridge

Single-outstanding APB master that converts a simple valid/ready request/response channel into APB4 transfers on the bus feeding the `apb_dpmem` slave. It sits directly upstream of the slave. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB through the `apb_if` master signals and returns PRDATA/PSLVERR on a response channel. A programmable PREADY timeout keeps a hung slave from stalling the requester forever.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles before a forced error response; 0 disables the timeout.

Ports (clock and reset fixed: one clock; reset is asynchronous and active-low):
- PCLK  in  1  system clock
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both valid and ready are high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  addr_t  transfer address
- req_wdata  in  data_t  write data
- req_strb  in  strb_t  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both valid and ready are high
- rsp_rdata  out  data_t  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR at completion, or 1 on timeout
- apb  mst_mp  apb_if  APB master signals (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB out; PREADY, PRDATA, PSLVERR in)

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- Accept: latch the request into the registered APB outputs and go to SETUP. For reads, PSTRB is 0 and PWDATA keeps its old value.
- SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - On PREADY: capture PRDATA (reads only; 0 for writes) and PSLVERR into rsp_rdata/rsp_err, then go to RESP.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still 0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - PREADY in the same cycle as the limit wins, giving a normal completion.
- RESP: PSEL=PENABLE=0, rsp_valid=1.
  - rsp_ready=1 and req_valid=1: accept the new request and go to SETUP.
  - rsp_ready=1 and req_valid=0: go to IDLE.
  - rsp_ready=0: hold rsp_rdata/rsp_err stable.
- PADDR/PWRITE/PWDATA/PSTRB change only on acceptance, so they are stable from SETUP through ACCESS.
- PRESETn low at any time (including mid-transfer): immediately return to IDLE and zero all outputs. The in-flight transfer is dropped with no response.

## Timing
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 combinationally once out of reset.
- All APB outputs and response outputs are registered. req_ready is combinational from state and rsp_ready.
- Zero-wait transfer: accept at edge N; SETUP in cycle N+1; ACCESS in N+2 (PREADY sampled); rsp_valid in N+3.
- Back-to-back with rsp_ready tied high: one transfer every 3 cycles.
- Each PREADY-low cycle adds one cycle of latency.
- Timeout response appears TIMEOUT_CYCLES+1 cycles after ACCESS entry.

## Structure
- apb_pkg gains:
  - ADDR_WIDTH and DATA_WIDTH constants, with STRB_WIDTH = DATA_WIDTH/8 (addr_t/data_t/strb_t already live there).
  - mst_state_e enum {IDLE, SETUP, ACCESS, RESP}.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Single module; no sub-module is warranted. The counter is inline.
- Bind the existing monitor_mp assertions on the bus for PSEL/PENABLE sequencing and signal stability.

## Test plan
Bench uses DATA_WIDTH=32 and TIMEOUT_CYCLES=4.
- Write, zero-wait: req write addr 0x10, wdata 0xDEADBEEF, strb 0xF → PSEL rises at N+1, PENABLE at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read with wait states: read 0x10 while the slave holds PREADY low 2 cycles, then returns 0xDEADBEEF → ACCESS lasts 3 cycles, rsp_rdata=0xDEADBEEF, PSTRB=0 throughout.
- Slave error: PSLVERR=1 with PREADY → rsp_err=1; PSEL drops the next cycle.
- Timeout: PREADY stuck at 0 → response after 5 ACCESS cycles with rsp_err=1, rsp_rdata=0, and PSEL deasserted.
- Backpressure and back-to-back: rsp_ready low 3 cycles holds the response stable and req_ready=0. When rsp_ready rises with a queued request, SETUP starts the next cycle.
- Mid-transfer reset: PRESETn pulsed low during ACCESS → all outputs are 0 asynchronously, no response is issued, and a request after reset completes normally.
